// File: rtl/reg_read_stage.sv
// reg_read_stage: operand fetch with a 32 x XLEN register file (x0 = 0) and a pending-bit RAW scoreboard.
// Define REG_READ_STAGE_BYPASS_EN to forward same-cycle write-back data into the fetched operands.
module reg_read_stage #(
  parameter int XLEN       = 32,
  parameter int REG_NUM    = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_inst,
  output logic [XLEN-1:0]       out_rs1,
  output logic [XLEN-1:0]       out_rs2,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  output logic [REG_NUM-1:0]    pending
);

  // Handshake: a transfer happens on a posedge where valid && ready. out_valid never depends on
  // out_ready, and a presented bundle holds every output stable until it is taken.
  localparam logic [6:0] OP_REG = 7'b0110011;

  logic [XLEN-1:0]       rf_q [REG_NUM];
  logic [REG_NUM-1:0]    pending_q, pending_d;
  logic                  out_valid_q, out_valid_d;
  logic [XLEN-1:0]       out_inst_q, out_inst_d;
  logic [XLEN-1:0]       out_rs1_q, out_rs1_d;
  logic [XLEN-1:0]       out_rs2_q, out_rs2_d;

  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic [6:0]            opcode;
  logic                  fwd1, fwd2;
  logic                  hazard;
  logic                  accept;
  logic                  wb_en;
  logic [XLEN-1:0]       rs1_val, rs2_val;

  assign rs1    = in_inst[19:15];
  assign rs2    = in_inst[24:20];
  assign rd     = in_inst[11:7];
  assign opcode = in_inst[6:0];

`ifdef REG_READ_STAGE_BYPASS_EN
  assign fwd1 = wb_valid && (wb_addr == rs1) && (rs1 != '0);
  assign fwd2 = wb_valid && (wb_addr == rs2) && (rs2 != '0);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // Both source fields are checked regardless of opcode; this only ever costs extra stalls.
  assign hazard = ((rs1 != '0) && pending_q[rs1] && !fwd1) ||
                  ((rs2 != '0) && pending_q[rs2] && !fwd2);
  assign in_ready = !rst && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign wb_en    = wb_valid && (wb_addr != '0);

  assign rs1_val = (rs1 == '0) ? '0 : (fwd1 ? wb_data : rf_q[rs1]);
  assign rs2_val = (rs2 == '0) ? '0 : (fwd2 ? wb_data : rf_q[rs2]);

  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    pending_d   = pending_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_inst_d  = in_inst;
      out_rs1_d   = rs1_val;
      out_rs2_d   = rs2_val;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (wb_en) pending_d[wb_addr] = 1'b0;
    // Set after clear so a new producer of the same register keeps it pending.
    if (accept && (opcode == OP_REG) && (rd != '0)) pending_d[rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      pending_q   <= '0;
      for (int i = 0; i < REG_NUM; i++) rf_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      pending_q   <= pending_d;
      if (wb_en) rf_q[wb_addr] <= wb_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_rs1   = out_rs1_q;
  assign out_rs2   = out_rs2_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: directed vector table plus randomized traffic against an array-based model.
module tb_reg_read_stage;

`ifdef REG_READ_STAGE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int W = 96;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst, out_rs1, out_rs2;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] pending;

  reg_read_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .pending(pending)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model and scoreboard
  int          checks = 0;
  int          failures = 0;
  logic [31:0] rf_m [32];
  logic [31:0] pend_m;
  logic        ov_m;
  logic [31:0] oinst_m, ors1_m, ors2_m;
  logic        rdy_dut;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rd,
                                         input logic [4:0] s1, input logic [4:0] s2);
    return {f7, s2, s1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [4:0] rd, input logic [4:0] s1,
                                         input logic [11:0] imm);
    return {imm, s1, 3'b000, rd, 7'b0010011};
  endfunction

  // ---------------- driver: one clock cycle with model update and checks
  task automatic run_cycle(input logic r, input logic iv, input logic [31:0] inst,
                           input logic ordy, input logic wv, input logic [4:0] wa,
                           input logic [31:0] wd);
    logic [4:0]  s1, s2, d;
    logic        f1, f2, haz, rdy, acc;
    logic [31:0] v1, v2;
    logic [W-1:0] front;
    @(negedge clk);
    rst = r; in_valid = iv; in_inst = inst; out_ready = ordy;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    #1;
    s1 = inst[19:15]; s2 = inst[24:20]; d = inst[11:7];
    f1  = BYPASS && wv && (wa == s1) && (s1 != 0);
    f2  = BYPASS && wv && (wa == s2) && (s2 != 0);
    haz = ((s1 != 0) && pend_m[s1] && !f1) || ((s2 != 0) && pend_m[s2] && !f2);
    rdy = !r && !haz && (!ov_m || ordy);
    rdy_dut = in_ready;
    check("in_ready", {95'b0, in_ready}, {95'b0, rdy});
    if (!r && ov_m && ordy) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_bundle", {out_inst, out_rs1, out_rs2}, '0);
      end else begin
        front = exp_q.pop_front();
        check("sb_bundle", {out_inst, out_rs1, out_rs2}, front);
      end
    end
    if (r) begin
      ov_m = 1'b0; oinst_m = '0; ors1_m = '0; ors2_m = '0; pend_m = '0;
      for (int i = 0; i < 32; i++) rf_m[i] = '0;
      exp_q.delete();
    end else begin
      acc = iv && rdy;
      v1 = (s1 == 0) ? 32'd0 : (f1 ? wd : rf_m[s1]);
      v2 = (s2 == 0) ? 32'd0 : (f2 ? wd : rf_m[s2]);
      if (acc) begin
        ov_m = 1'b1; oinst_m = inst; ors1_m = v1; ors2_m = v2;
        exp_q.push_back({inst, v1, v2});
      end else if (ordy) begin
        ov_m = 1'b0;
      end
      if (wv && wa != 0) begin
        rf_m[wa] = wd;
        pend_m[wa] = 1'b0;
      end
      if (acc && inst[6:0] == 7'b0110011 && d != 0) pend_m[d] = 1'b1;
    end
    @(posedge clk);
    #1;
    check("out_valid", {95'b0, out_valid}, {95'b0, ov_m});
    check("out_inst", {64'b0, out_inst}, {64'b0, oinst_m});
    check("out_rs1", {64'b0, out_rs1}, {64'b0, ors1_m});
    check("out_rs2", {64'b0, out_rs2}, {64'b0, ors2_m});
    check("pending", {64'b0, pending}, {64'b0, pend_m});
  endtask

  // ---------------- directed vector table
  typedef struct {
    logic r, iv; logic [31:0] inst; logic ordy, wv; logic [4:0] wa; logic [31:0] wd;
    logic e_rdy, e_ov; logic [31:0] e_rs1, e_rs2, e_pend;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic iv, input logic [31:0] inst,
                         input logic ordy, input logic wv, input logic [4:0] wa,
                         input logic [31:0] wd, input logic e_rdy, input logic e_ov,
                         input logic [31:0] e_rs1, input logic [31:0] e_rs2,
                         input logic [31:0] e_pend);
    vec_t v;
    v.r = r; v.iv = iv; v.inst = inst; v.ordy = ordy; v.wv = wv; v.wa = wa; v.wd = wd;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_pend = e_pend;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] add3, sub4, addi6, add7, add5, addi9;
    add3  = r_type(7'h00, 5'd3, 5'd1, 5'd2);
    sub4  = r_type(7'h20, 5'd4, 5'd3, 5'd1);
    addi6 = i_type(5'd6, 5'd1, 12'd0);
    add7  = r_type(7'h00, 5'd7, 5'd2, 5'd1);
    add5  = r_type(7'h00, 5'd5, 5'd1, 5'd2);
    addi9 = i_type(5'd9, 5'd1, 12'd0);

    //       r  iv inst   ordy wv wa  wd      rdy ov  rs1 rs2 pend
    add_vec(1, 0, 0,     0,   0, 0,  0,      0,  0,  0,  0,  32'h0);
    add_vec(0, 0, 0,     0,   1, 1,  5,      1,  0,  0,  0,  32'h0);
    add_vec(0, 0, 0,     0,   1, 2,  7,      1,  0,  0,  0,  32'h0);
    add_vec(0, 0, 0,     0,   1, 0,  9,      1,  0,  0,  0,  32'h0);
    add_vec(0, 0, 0,     0,   1, 3,  1,      1,  0,  0,  0,  32'h0);
    add_vec(0, 1, add3,  1,   0, 0,  0,      1,  1,  5,  7,  32'h8);
    add_vec(0, 1, sub4,  1,   0, 0,  0,      0,  0,  5,  7,  32'h8);
    add_vec(0, 1, sub4,  1,   0, 0,  0,      0,  0,  5,  7,  32'h8);
    add_vec(0, 1, sub4,  1,   0, 0,  0,      0,  0,  5,  7,  32'h8);
    if (BYPASS) begin
      add_vec(0, 1, sub4, 1,  1, 3,  12,     1,  1,  12, 5,  32'h10);
      add_vec(0, 0, 0,    1,  0, 0,  0,      1,  0,  12, 5,  32'h10);
    end else begin
      add_vec(0, 1, sub4, 1,  1, 3,  12,     0,  0,  5,  7,  32'h0);
      add_vec(0, 1, sub4, 1,  0, 0,  0,      1,  1,  12, 5,  32'h10);
      add_vec(0, 0, 0,    1,  0, 0,  0,      1,  0,  12, 5,  32'h10);
    end
    add_vec(0, 1, addi6, 1,   0, 0,  0,      1,  1,  5,  0,  32'h10);
    for (int i = 0; i < 5; i++)
      add_vec(0, 1, add7, 0,  0, 0,  0,      0,  1,  5,  0,  32'h10);
    add_vec(0, 1, add7,  1,   0, 0,  0,      1,  1,  7,  5,  32'h90);
    add_vec(0, 1, add5,  1,   1, 5,  3,      1,  1,  5,  7,  32'hB0);
    add_vec(0, 0, 0,     1,   1, 7,  1,      1,  0,  5,  7,  32'h30);
    add_vec(0, 1, add3,  1,   0, 0,  0,      1,  1,  5,  7,  32'h38);
    add_vec(1, 0, 0,     1,   0, 0,  0,      0,  0,  0,  0,  32'h0);
    add_vec(0, 1, addi9, 1,   0, 0,  0,      1,  1,  0,  0,  32'h0);
    add_vec(0, 0, 0,     1,   0, 0,  0,      1,  0,  0,  0,  32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_cycle(vecs[i].r, vecs[i].iv, vecs[i].inst, vecs[i].ordy,
                vecs[i].wv, vecs[i].wa, vecs[i].wd);
      check($sformatf("v%0d_in_ready", i), {95'b0, rdy_dut}, {95'b0, vecs[i].e_rdy});
      check($sformatf("v%0d_out_valid", i), {95'b0, out_valid}, {95'b0, vecs[i].e_ov});
      check($sformatf("v%0d_out_rs1", i), {64'b0, out_rs1}, {64'b0, vecs[i].e_rs1});
      check($sformatf("v%0d_out_rs2", i), {64'b0, out_rs2}, {64'b0, vecs[i].e_rs2});
      check($sformatf("v%0d_pending", i), {64'b0, pending}, {64'b0, vecs[i].e_pend});
    end

    // Randomized traffic on a small register window so hazards and forwarding collide often.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] inst;
      logic [4:0]  rd, s1, s2;
      rd = 5'($urandom_range(0, 7));
      s1 = 5'($urandom_range(0, 7));
      s2 = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) inst = r_type(7'($urandom_range(0, 1) * 32), rd, s1, s2);
      else inst = i_type(rd, s1, {7'($urandom), s2});
      run_cycle(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), inst,
                ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_read_stage.md
Name: reg_read_stage

Overview:
- Operand-fetch stage that produces the `inst`/`rs1`/`rs2` bundle the execute ALU consumes, and accepts the ALU's `rd` result back as write-back.
- Holds the 32×XLEN integer register file, with x0 hardwired to zero.
- Tracks in-flight destination registers with a pending-bit scoreboard and stalls on read-after-write hazards.
- Sits between decode (upstream valid/ready) and the execute ALU (downstream valid/ready).

Parameters:
- XLEN, 32, data width of registers and instruction word
- REG_NUM, 32, number of architectural registers
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept instruction this cycle
- in_inst  in  XLEN  instruction word; rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0]
- out_valid  out  1  operand bundle valid
- out_ready  in  1  ALU side accepts bundle
- out_inst  out  XLEN  registered instruction word
- out_rs1  out  XLEN  source operand 1 value
- out_rs2  out  XLEN  source operand 2 value
- wb_valid  in  1  write-back valid
- wb_addr  in  REG_ADDR_W  write-back register index
- wb_data  in  XLEN  write-back data (ALU rd)
- pending  out  REG_NUM  scoreboard bits, bit i = write to xi outstanding

Behaviour:
Reset (`rst` sampled high at posedge):
- out_valid=0; out_inst=0, out_rs1=0, out_rs2=0.
- pending=0; all register file entries=0.
- wb ignored that cycle.
- in_ready=0 while rst is high.

Hazard and accept:
- hazard = (rs1!=0 && pending[rs1] && !fwd1) || (rs2!=0 && pending[rs2] && !fwd2).
- fwdN = wb_valid && wb_addr==rsN && rsN!=0 (bypass build only; otherwise 0).
- in_ready = !rst && !hazard && (!out_valid || out_ready). Combinational.
- Accept = in_valid && in_ready. Both source fields are checked for every opcode (conservative).

Capture on accept (1-cycle latency):
- At the accepting posedge: out_valid<=1, out_inst<=in_inst.
- out_rsN <= 0 if rsN==0; else wb_data if fwdN; else rf[rsN] (pre-write value).

Output handshake:
- out_valid && !out_ready: all outputs hold stable.
- out_valid && out_ready && !accept: out_valid<=0 next edge.
- Accept while draining: back-to-back, out_valid stays 1 with new bundle.

Write-back:
- wb_valid && wb_addr!=0: rf[wb_addr]<=wb_data and pending[wb_addr]<=0.
- wb to x0 is a no-op.

Scoreboard set:
- Accept of opcode 7'b0110011 with rd!=0 sets pending[rd].
- Same-edge set and clear on the same index: set wins.

Other cases:
- Write-back to a non-pending register is legal: rf is updated, no error.
- rst mid-stall or with a held output: the bundle is dropped and the scoreboard cleared.

Optional Feature:
- Macro: REG_READ_STAGE_BYPASS_EN.
- Defined: same-cycle write-back is forwarded to matching sources (fwdN as above), so a pending source resolves with no stall cycle.
- Undefined: fwdN=0. A pending source whose write-back arrives this cycle stalls one cycle, then reads the updated rf next cycle. A non-pending source matching a same-cycle wb reads the old rf value.

Test Plan:
- Reset, then 4 cycles of wb (x1=5, x2=7, x0=9, x3=1) -> rf x1=5, x2=7, x0 reads 0; pending all 0.
- Issue `add x3,x1,x2` with out_ready=1 -> next cycle out_valid=1, out_rs1=5, out_rs2=7; pending[3]=1.
- Issue `sub x4,x3,x1` while pending[3]=1, no wb -> in_ready=0 for 3 cycles. Then wb x3=12: bypass build accepts that edge with out_rs1=12; non-bypass build accepts one edge later with out_rs1=12.
- Hold out_ready=0 with out_valid=1 and in_valid=1 -> in_ready=0, outputs unchanged 5 cycles. Raise out_ready -> new bundle next edge with no bubble.
- Accept `add x5,...` on the same edge as wb x5=3 -> pending[5]=1 after the edge; rf[5]=3.
- Assert rst for 1 cycle with out_valid=1 and pending[3]=1 -> out_valid=0, pending=0, rf[1] reads 0 afterwards.
